aludec: RTL and testbench
=========================

ALUDEC -- requirements
Module: aludec

Interface
- No parameters.
- REQ-001: clk  input  1  rising-edge clock for the output registers.
- REQ-002: reset  input  1  asynchronous, active-high reset.
- REQ-003: op  input  4  instruction opcode/function field.
- REQ-004: aluop  input  2  ALU operation class from the main decoder.
- REQ-005: alucontrol  output  4  registered ALU control code.
- REQ-006: illegal  output  1  registered flag; high when aluop=10 carries an unsupported op.

Function
- REQ-007: ALU control codes SHALL be:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 NOR, 0101 SLL, 0110 SUB, 0111 SLT
  - 1000 SRL, 1001 SRA, 1111 PASS-B
- REQ-008: aluop=00 SHALL select ADD (0010) regardless of op, for load/store/address arithmetic.
- REQ-009: aluop=01 SHALL select SUB (0110) regardless of op, for branch compare.
- REQ-010: aluop=11 SHALL select PASS-B (1111) regardless of op, for load-immediate/move.
- REQ-011: With aluop=10, op SHALL decode as:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA
- REQ-012: aluop=10 with op in 1010..1111 SHALL select ADD (0010) and set illegal=1.
- REQ-013: Every case other than REQ-012 SHALL produce illegal=0.
- REQ-014: Decoding SHALL be combinational from the op and aluop inputs.
- REQ-015: Decode results SHALL be captured on every rising clk edge, giving a latency of exactly one cycle from input to alucontrol/illegal.
- REQ-016: Outputs SHALL change only on a clk edge or on reset assertion.
- REQ-017: There is no enable or handshake; a new decode is accepted every cycle.
- REQ-018: The decode SHALL be a full case with a defined default (ADD, illegal=0 for non-10 classes). No latch SHALL be inferred.
- REQ-019: Outputs SHALL never be X after reset, for all 64 input combinations.
- REQ-020: Input changes between clock edges SHALL NOT affect outputs until the next rising edge.

Reset
- REQ-021: While reset=1, alucontrol SHALL be 0010 (ADD) and illegal SHALL be 0, asynchronously and independent of clk.
- REQ-022: An input present during reset SHALL NOT be presented after release. The first decoded value SHALL appear at the first rising clk edge with reset=0.
- REQ-023: Reset asserted mid-operation SHALL override any pending decode immediately.

Verification
- REQ-024: reset=1, then release; op=0001, aluop=10 -> after next edge alucontrol=0110, illegal=0.
- REQ-025: op=0000, aluop=10 -> alucontrol=0010. Then op=1100, aluop=00 -> alucontrol=0010. Each result appears one cycle later.
- REQ-026: op=1110, aluop=01 -> 0110. Then op=1010, aluop=11 -> 1111. Then op=1010, aluop=10 -> 0010 with illegal=1.
- REQ-027: Sweep all 16 op values with aluop=10 -> each output matches the REQ-011/REQ-012 table one cycle later.
- REQ-028: Reset mid-operation: drive op=0110, aluop=10 (alucontrol=0111), then assert reset between edges -> alucontrol=0010 and illegal=0 immediately, with no clk edge required.
- REQ-029: Change the inputs mid-cycle -> outputs hold until the next rising edge.

Source files
------------

// File: rtl/aludec_if.sv
// ALU decoder bus: decode inputs from the main decoder and the registered ALU control result.
interface aludec_if;
  logic [3:0] op;
  logic [1:0] aluop;
  logic [3:0] alucontrol;
  logic       illegal;

  modport master (
    output op,
    output aluop,
    input  alucontrol,
    input  illegal
  );

  modport slave (
    input  op,
    input  aluop,
    output alucontrol,
    output illegal
  );
endinterface

// File: rtl/aludec.sv
// ALU control decoder: maps opcode class and function field to an ALU control code,
// registered with one cycle of latency and an asynchronous active-high reset to ADD.
module aludec (
  input logic     clk,
  input logic     reset,
  aludec_if.slave bus
);

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluNor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluPass = 4'b1111;

  logic [3:0] alucontrol_d, alucontrol_q;
  logic       illegal_d, illegal_q;

  always_comb begin
    alucontrol_d = AluAdd;
    illegal_d    = 1'b0;
    unique case (bus.aluop)
      2'b00: alucontrol_d = AluAdd;
      2'b01: alucontrol_d = AluSub;
      2'b11: alucontrol_d = AluPass;
      2'b10: begin
        case (bus.op)
          4'b0000: alucontrol_d = AluAdd;
          4'b0001: alucontrol_d = AluSub;
          4'b0010: alucontrol_d = AluAnd;
          4'b0011: alucontrol_d = AluOr;
          4'b0100: alucontrol_d = AluXor;
          4'b0101: alucontrol_d = AluNor;
          4'b0110: alucontrol_d = AluSlt;
          4'b0111: alucontrol_d = AluSll;
          4'b1000: alucontrol_d = AluSrl;
          4'b1001: alucontrol_d = AluSra;
          // Unsupported function codes fall back to ADD and are flagged.
          default: begin
            alucontrol_d = AluAdd;
            illegal_d    = 1'b1;
          end
        endcase
      end
      default: begin
        alucontrol_d = AluAdd;
        illegal_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alucontrol_q <= AluAdd;
      illegal_q    <= 1'b0;
    end else begin
      alucontrol_q <= alucontrol_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.alucontrol = alucontrol_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_aludec.sv
// Self-checking bench for aludec: directed vector table, reset/hold sequences and a
// randomized run against a table-lookup reference model.
module tb_aludec;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  aludec_if bus ();

  aludec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [1:0] aluop;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  // Reference: fixed classes map to one code, R-type looks up the function table.
  function automatic logic [4:0] model(input logic [3:0] op, input logic [1:0] aluop);
    logic [3:0] rtype [0:15];
    rtype = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'h4, 4'h7, 4'h5,
              4'h8, 4'h9, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
    case (aluop)
      2'd0:    return {4'h2, 1'b0};
      2'd1:    return {4'h6, 1'b0};
      2'd3:    return {4'hf, 1'b0};
      default: return {rtype[op], (op >= 4'd10)};
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] exp_c, input logic exp_i);
    checks++;
    if (bus.alucontrol !== exp_c || bus.illegal !== exp_i) begin
      failures++;
      $display("FAIL %s: got alucontrol=%b illegal=%b, expected alucontrol=%b illegal=%b",
               name, bus.alucontrol, bus.illegal, exp_c, exp_i);
    end
  endtask

  // Drive at the falling edge, sample just after the next rising edge.
  task automatic step(input logic [3:0] op, input logic [1:0] aluop);
    @(negedge clk);
    bus.op    = op;
    bus.aluop = aluop;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    logic [4:0] exp;
    logic [3:0] rop;
    logic [1:0] ralu;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{4'b0001, 2'b10, 4'b0110, 1'b0});
    vecs.push_back('{4'b0000, 2'b10, 4'b0010, 1'b0});
    vecs.push_back('{4'b1100, 2'b00, 4'b0010, 1'b0});
    vecs.push_back('{4'b1110, 2'b01, 4'b0110, 1'b0});
    vecs.push_back('{4'b1010, 2'b11, 4'b1111, 1'b0});
    vecs.push_back('{4'b1010, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b0010, 2'b10, 4'b0000, 1'b0});
    vecs.push_back('{4'b0011, 2'b10, 4'b0001, 1'b0});
    vecs.push_back('{4'b0100, 2'b10, 4'b0011, 1'b0});
    vecs.push_back('{4'b0101, 2'b10, 4'b0100, 1'b0});
    vecs.push_back('{4'b0110, 2'b10, 4'b0111, 1'b0});
    vecs.push_back('{4'b0111, 2'b10, 4'b0101, 1'b0});
    vecs.push_back('{4'b1000, 2'b10, 4'b1000, 1'b0});
    vecs.push_back('{4'b1001, 2'b10, 4'b1001, 1'b0});
    vecs.push_back('{4'b1011, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b1100, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b1101, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b1110, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b1111, 2'b10, 4'b0010, 1'b1});
    vecs.push_back('{4'b1111, 2'b00, 4'b0010, 1'b0});
    vecs.push_back('{4'b0000, 2'b11, 4'b1111, 1'b0});

    // Reset with a non-default input pending.
    reset     = 1'b1;
    bus.op    = 4'b0111;
    bus.aluop = 2'b11;
    #2;
    check("reset_async", 4'b0010, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", 4'b0010, 1'b0);

    // Release between edges; pending input must not show until the next edge.
    @(negedge clk);
    bus.op    = 4'b0001;
    bus.aluop = 2'b10;
    reset     = 1'b0;
    #2;
    check("release_no_edge", 4'b0010, 1'b0);
    @(posedge clk);
    #1;
    check("first_decode", 4'b0110, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].aluop);
      check($sformatf("vec%0d op=%b aluop=%b", i, vecs[i].op, vecs[i].aluop),
            vecs[i].ctrl, vecs[i].ill);
    end

    // Mid-cycle input change must not reach outputs before the next edge.
    step(4'b0110, 2'b10);
    check("hold_pre", 4'b0111, 1'b0);
    bus.op    = 4'b1100;
    bus.aluop = 2'b10;
    #3;
    check("hold_mid", 4'b0111, 1'b0);
    @(posedge clk);
    #1;
    check("hold_after_edge", 4'b0010, 1'b1);

    // Reset asserted between edges overrides immediately.
    step(4'b0110, 2'b10);
    check("pre_midreset", 4'b0111, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_async", 4'b0010, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_midreset", 4'b0111, 1'b0);

    // Randomized run against the reference model.
    for (int n = 0; n < 300; n++) begin
      rop  = 4'($urandom_range(0, 15));
      ralu = 2'($urandom_range(0, 3));
      step(rop, ralu);
      exp = model(rop, ralu);
      check($sformatf("rand%0d op=%b aluop=%b", n, rop, ralu), exp[4:1], exp[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
